// File: rtl/exec_pkg.sv
// exec_pkg: opcode constants, slot state encoding and the shared ALU compute function
// Operands are zero-extended to MAX_W before compute; callers keep the low DATA_W bits,
// which gives wrap-around modulo 2^DATA_W for add, sub and the low half of mul.
package exec_pkg;
  localparam int MAX_W = 64;
  localparam int OPC_MAX_W = 8;
  localparam logic [OPC_MAX_W-1:0] OP_SUB = 8'h0;
  localparam logic [OPC_MAX_W-1:0] OP_ADD = 8'h1;
  localparam logic [OPC_MAX_W-1:0] OP_MUL = 8'h2;
  localparam logic [OPC_MAX_W-1:0] OP_DIV = 8'h3;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_state_e;
  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic err;
  } exec_res_t;
  function automatic exec_res_t exec_compute(input logic [OPC_MAX_W-1:0] opc,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
    exec_res_t r;
    r.err = (opc > OP_DIV) || (opc == OP_DIV && b == '0);
    r.value = opc == OP_SUB ? a - b :
              opc == OP_ADD ? a + b :
              opc == OP_MUL ? a * b :
              opc == OP_DIV ? (b == '0 ? '1 : a / b) : '0;
    return r;
  endfunction
endpackage

// File: rtl/exec_slot.sv
// exec_slot: one fixed-latency ALU slot holding operands, tag, latency counter and result
// Ports: start captures opcode/src1/src2/tag (only asserted while idle); accept releases a
// DONE slot; busy = BUSY or DONE; done = DONE; res_* hold the tag and the computed result.
module exec_slot
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OPC_W   = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [TAG_W-1:0]  tag,
  input  logic              accept,
  output logic              busy,
  output logic              done,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_value,
  output logic              res_err
);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  slot_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OPC_W-1:0] opc_q;
  logic [DATA_W-1:0] a_q, b_q;
  exec_res_t res;
  logic [MAX_W-DATA_W:0] unused_hi;
  assign res = exec_compute(OPC_MAX_W'(opc_q), MAX_W'(a_q), MAX_W'(b_q));
  assign unused_hi = res.value[MAX_W-1:DATA_W-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE && start) ? BUSY :
              (state_q == BUSY && cnt_q == '0) ? DONE :
              (state_q == DONE && accept) ? IDLE : state_q;
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q     <= '0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_tag   <= '0;
      res_value <= '0;
      res_err   <= 1'b0;
    end else begin
      if (start) begin
        opc_q   <= opcode;
        a_q     <= src1;
        b_q     <= src2;
        res_tag <= tag;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if (state_q == BUSY && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (state_q == BUSY && cnt_q == '0) begin
        res_value <= res.value[DATA_W-1:0];
        res_err   <= res.err;
      end
    end
endmodule

// File: rtl/exec_dispatch_unit.sv
// exec_dispatch_unit: dispatches ready reservation-station entries to ALU slots, returns results round-robin
// Ports: rs_* describe DEPTH packed entries; rs_grant pulses (registered) for each entry captured
// by a slot; unit_busy flags occupied slots; res_valid/res_ready hand off one result per cycle
// with res_tag/res_value/res_err, which hold their last values while no result is pending.
module exec_dispatch_unit
  import exec_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 2,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int OPC_W     = 4,
  parameter int LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DEPTH-1:0]        rs_valid,
  input  logic [DEPTH-1:0]        rs_ready,
  input  logic [DEPTH*OPC_W-1:0]  rs_opcode,
  input  logic [DEPTH*DATA_W-1:0] rs_src1,
  input  logic [DEPTH*DATA_W-1:0] rs_src2,
  input  logic [DEPTH*TAG_W-1:0]  rs_tag,
  output logic [DEPTH-1:0]        rs_grant,
  output logic [NUM_UNITS-1:0]    unit_busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [TAG_W-1:0]        res_tag,
  output logic [DATA_W-1:0]       res_value,
  output logic                    res_err
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  logic [DEPTH-1:0] issued_q, eligible, avail, grant_d;
  logic [NUM_UNITS-1:0] start, done, accept;
  logic [IDX_W-1:0] pick [NUM_UNITS];
  logic found, any;
  logic [UW-1:0] ptr_q, sel, cand;
  logic [TAG_W-1:0] s_tag [NUM_UNITS];
  logic [DATA_W-1:0] s_val [NUM_UNITS];
  logic s_err [NUM_UNITS];
  logic [TAG_W-1:0] last_tag;
  logic [DATA_W-1:0] last_val;
  logic last_err;
  assign eligible = rs_valid & rs_ready & ~issued_q;
  // k-th eligible entry (ascending) pairs with k-th idle slot (ascending); a slot released
  // this cycle still reads busy, so it only becomes grantable next cycle.
  always_comb begin
    avail   = eligible;
    grant_d = '0;
    start   = '0;
    found   = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      pick[u] = '0;
      found   = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (!unit_busy[u] && !found && avail[i]) begin
          found      = 1'b1;
          avail[i]   = 1'b0;
          grant_d[i] = 1'b1;
          start[u]   = 1'b1;
          pick[u]    = IDX_W'(i);
        end
    end
  end
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
    exec_slot #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .OPC_W  (OPC_W),
      .LATENCY(LATENCY)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .start    (start[u]),
      .opcode   (rs_opcode[pick[u]*OPC_W +: OPC_W]),
      .src1     (rs_src1[pick[u]*DATA_W +: DATA_W]),
      .src2     (rs_src2[pick[u]*DATA_W +: DATA_W]),
      .tag      (rs_tag[pick[u]*TAG_W +: TAG_W]),
      .accept   (accept[u]),
      .busy     (unit_busy[u]),
      .done     (done[u]),
      .res_tag  (s_tag[u]),
      .res_value(s_val[u]),
      .res_err  (s_err[u])
    );
  end
  // First DONE slot at or after the pointer. On a stall the pointer parks on the presented
  // slot, which keeps res_* stable even if an earlier-priority slot completes meanwhile.
  always_comb begin
    any    = 1'b0;
    sel    = ptr_q;
    cand   = '0;
    accept = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = UW'((int'(ptr_q) + k) % NUM_UNITS);
      if (!any && done[cand]) begin
        any = 1'b1;
        sel = cand;
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) accept[u] = any && res_ready && sel == UW'(u);
  end
  assign res_valid = any;
  assign res_tag   = any ? s_tag[sel] : last_tag;
  assign res_value = any ? s_val[sel] : last_val;
  assign res_err   = any ? s_err[sel] : last_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      issued_q <= '0;
      rs_grant <= '0;
      ptr_q    <= '0;
      last_tag <= '0;
      last_val <= '0;
      last_err <= 1'b0;
    end else begin
      issued_q <= (issued_q | grant_d) & rs_valid;
      rs_grant <= grant_d;
      if (any) begin
        ptr_q    <= !res_ready ? sel : int'(sel) == NUM_UNITS - 1 ? '0 : sel + 1'b1;
        last_tag <= s_tag[sel];
        last_val <= s_val[sel];
        last_err <= s_err[sel];
      end
    end
endmodule

// File: tb/tb_exec_dispatch_unit.sv
// tb_exec_dispatch_unit: scoreboard bench for the default unit and an 8-bit, latency-1 variant
module tb_exec_dispatch_unit;
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0] v, rd, grant, rt;
  logic [15:0] opc, tg;
  logic [127:0] a, b;
  logic [1:0] busy;
  logic rv, rr, rerr;
  logic [31:0] rval;
  logic [3:0] v8, rd8, grant8, rt8;
  logic [15:0] opc8, tg8;
  logic [31:0] a8, b8;
  logic [1:0] busy8;
  logic rv8, rr8, rerr8;
  logic [7:0] rval8;
  exp_t q[$];
  exp_t q8[$];
  int checks = 0, failures = 0, cyc = 0, first_acc = -1;
  int gtick[4];
  exec_dispatch_unit u_dut (
    .clk(clk), .rst(rst), .rs_valid(v), .rs_ready(rd), .rs_opcode(opc), .rs_src1(a),
    .rs_src2(b), .rs_tag(tg), .rs_grant(grant), .unit_busy(busy), .res_valid(rv),
    .res_ready(rr), .res_tag(rt), .res_value(rval), .res_err(rerr)
  );
  exec_dispatch_unit #(.DATA_W(8), .LATENCY(1)) u_dut8 (
    .clk(clk), .rst(rst), .rs_valid(v8), .rs_ready(rd8), .rs_opcode(opc8), .rs_src1(a8),
    .rs_src2(b8), .rs_tag(tg8), .rs_grant(grant8), .unit_busy(busy8), .res_valid(rv8),
    .res_ready(rr8), .res_tag(rt8), .res_value(rval8), .res_err(rerr8)
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic load(input int i, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] t, input logic [31:0] ev, input logic ee);
    v[i] = 1'b1;
    rd[i] = 1'b1;
    opc[i*4 +: 4] = o;
    a[i*32 +: 32] = x;
    b[i*32 +: 32] = y;
    tg[i*4 +: 4] = t;
    q.push_back('{t, ev, ee});
  endtask
  task automatic load8(input int i, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] t, input logic [7:0] ev, input logic ee);
    v8[i] = 1'b1;
    rd8[i] = 1'b1;
    opc8[i*4 +: 4] = o;
    a8[i*8 +: 8] = x;
    b8[i*8 +: 8] = y;
    tg8[i*4 +: 4] = t;
    q8.push_back('{t, 32'(ev), ee});
  endtask
  task automatic tick();
    exp_t e;
    #1;
    if (rv && rr) begin
      if (q.size() == 0) check("res_extra", 64'(q.size()), 64'(1));
      else begin
        e = q.pop_front();
        check("res_tag", 64'(rt), 64'(e.tag));
        check("res_value", 64'(rval), 64'(e.val));
        check("res_err", 64'(rerr), 64'(e.err));
      end
      if (first_acc < 0) first_acc = cyc + 1;
    end
    if (rv8 && rr8) begin
      if (q8.size() == 0) check("res8_extra", 64'(q8.size()), 64'(1));
      else begin
        e = q8.pop_front();
        check("res8_tag", 64'(rt8), 64'(e.tag));
        check("res8_value", 64'(rval8), 64'(e.val));
        check("res8_err", 64'(rerr8), 64'(e.err));
      end
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) begin
        v[i] = 1'b0;
        gtick[i] = cyc;
      end
      if (grant8[i]) v8[i] = 1'b0;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    q8.delete();
    v = '0;
    v8 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    {v, rd, opc, a, b, tg, rr} = '0;
    {v8, rd8, opc8, a8, b8, tg8, rr8} = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(rv), 64'(0));
    check("rst_tag", 64'(rt), 64'(0));
    check("rst_value", 64'(rval), 64'(0));
    check("rst_err", 64'(rerr), 64'(0));
    check("rst8_busy", 64'(busy8), 64'(0));
    check("rst8_valid", 64'(rv8), 64'(0));
    rst = 1'b0;
    rr = 1'b1;
    rr8 = 1'b1;
    load(0, 4'h1, 5, 7, 3, 12, 1'b0);
    tick();
    check("add_grant", 64'(grant), 64'(1));
    tick();
    check("add_early", 64'(rv), 64'(0));
    tick();
    check("add_valid", 64'(rv), 64'(1));
    tick();
    check("add_drain", 64'(q.size()), 64'(0));
    do_reset();
    first_acc = -1;
    foreach (gtick[i]) gtick[i] = -1;
    load(0, 4'h0, 10, 3, 1, 7, 1'b0);
    load(1, 4'h1, 1, 1, 2, 2, 1'b0);
    load(2, 4'h2, 6, 7, 4, 42, 1'b0);
    load(3, 4'h3, 9, 2, 5, 4, 1'b0);
    repeat (10) tick();
    check("four_pair", 64'(gtick[1]), 64'(gtick[0]));
    check("four_g2", 64'(gtick[2]), 64'(first_acc + 1));
    check("four_g3", 64'(gtick[3]), 64'(gtick[2] + 1));
    check("four_drain", 64'(q.size()), 64'(0));
    load(0, 4'h3, 8, 0, 6, 32'hFFFF_FFFF, 1'b1);
    load(1, 4'h7, 3, 4, 7, 0, 1'b1);
    repeat (5) tick();
    check("err_drain", 64'(q.size()), 64'(0));
    rr = 1'b0;
    load(0, 4'h1, 1, 2, 8, 3, 1'b0);
    load(1, 4'h0, 9, 4, 9, 5, 1'b0);
    load(2, 4'h1, 3, 3, 10, 6, 1'b0);
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(rv), 64'(1));
      check("bp_tag", 64'(rt), 64'(8));
      check("bp_value", 64'(rval), 64'(3));
      check("bp_busy", 64'(busy), 64'(3));
      check("bp_nogrant", 64'(grant), 64'(0));
      tick();
    end
    rr = 1'b1;
    tick();
    check("bp_next_valid", 64'(rv), 64'(1));
    check("bp_next_tag", 64'(rt), 64'(9));
    repeat (5) tick();
    check("bp_drain", 64'(q.size()), 64'(0));
    load8(0, 4'h1, 8'hFF, 8'h02, 1, 8'h01, 1'b0);
    load8(1, 4'h0, 8'h00, 8'h01, 2, 8'hFF, 1'b0);
    tick();
    check("w_grant", 64'(grant8), 64'(3));
    tick();
    check("w_valid", 64'(rv8), 64'(1));
    repeat (3) tick();
    check("w_drain", 64'(q8.size()), 64'(0));
    load(0, 4'h2, 3, 4, 5, 12, 1'b0);
    tick();
    check("mid_grant", 64'(grant), 64'(1));
    tick();
    check("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_valid", 64'(rv), 64'(0));
    check("mid_rst_grant", 64'(grant), 64'(0));
    check("mid_rst_tag", 64'(rt), 64'(0));
    check("mid_rst_value", 64'(rval), 64'(0));
    check("mid_rst_err", 64'(rerr), 64'(0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("mid_no_stale", 64'(rv), 64'(0));
    load(0, 4'h2, 3, 4, 5, 12, 1'b0);
    tick();
    check("mid_regrant", 64'(grant), 64'(1));
    repeat (3) tick();
    check("mid_drain", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
